unidade_controle: RTL and testbench
===================================

# unidade_controle

Multi-cycle control unit for the processor core. Sequences every instruction through fetch, decode, execute, memory, write-back and PC-update states, driving the datapath strobes and the 4-bit `estado` bus that the PC-update stage samples. It sits directly upstream of the PC-update stage and supplies that stage's `estado`, `pcsrc`, `immediate` and `negativo` inputs.

## Interface
- No parameters; widths are fixed by the ISA subset.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instrucao` in 32: instruction word from instruction memory, valid during BUSCA.
- `zero` in 1: ALU result == 0, valid during EXECUTA.
- `menor` in 1: ALU signed rs1 < rs2, valid during EXECUTA.
- `mem_pronto` in 1: data-memory completion strobe.
- `estado` out 4: current state encoding.
- `pcsrc` out 1: 1 = taken branch, valid in ATUALIZA_PC.
- `immediate` out 12: branch offset magnitude in bytes.
- `negativo` out 1: branch offset sign, 1 = backward.
- `imm_alu` out 32: sign-extended I/S immediate.
- `ir_write`, `regwrite`, `memread`, `memwrite`, `alusrc` out 1 each: datapath strobes.
- `aluop` out 2: 00 add, 01 subtract/compare, 10 funct-decoded.
- `ilegal` out 1: one-cycle pulse on an unsupported opcode or an unrepresentable offset.

## Operation
- States: BUSCA 4'b0000, DECODIFICA 4'b0001, EXECUTA 4'b0010, MEMORIA 4'b0011, ESCRITA 4'b0100, ATUALIZA_PC 4'b1000.
- Reset: `estado`=BUSCA, internal IR=0, all other outputs 0.
- BUSCA: `ir_write`=1; IR <= `instrucao`. Next state: DECODIFICA.
- DECODIFICA: decode opcode from IR; register `immediate`, `negativo` and `imm_alu`.
  - Supported opcodes: 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch.
  - Any other opcode: pulse `ilegal`, go to ATUALIZA_PC with `pcsrc`=0.
  - Otherwise next state: EXECUTA.
- EXECUTA: `aluop` and `alusrc` are set per class.
  - Branch: register `pcsrc` from funct3 (000 beq: `zero`; 001 bne: !`zero`; 100 blt: `menor`; 101 bge: !`menor`; other funct3: 0 plus `ilegal`). Next state: ATUALIZA_PC.
  - Load/store: next state MEMORIA.
  - R/I: next state ESCRITA.
- MEMORIA: hold `memread` (load) or `memwrite` (store) until a cycle with `mem_pronto`=1; no timeout. On that cycle, load goes to ESCRITA and store goes to ATUALIZA_PC.
- ESCRITA: `regwrite`=1 for exactly one cycle. Next state: ATUALIZA_PC.
- ATUALIZA_PC: one cycle. Next state: BUSCA. `pcsrc` clears on exit.
- Branch immediate:
  - off = sign-extended {IR[31],IR[7],IR[30:25],IR[11:8],0}, 13 bits.
  - `negativo` = off[12].
  - `immediate` = |off|[11:0].
  - off = −4096 yields `immediate`=0 and `negativo`=1, and pulses `ilegal`.
- Non-branch instructions: `immediate`=0, `negativo`=0.

## Timing
- Cycles per instruction: branch/illegal 4 (illegal skips EXECUTA, so 3), R/I 5, store 5+w, load 6+w, where w = wait cycles before `mem_pronto`.
- `immediate`, `negativo` and `pcsrc` are stable from their registration through the whole ATUALIZA_PC cycle.
- `mem_pronto` is ignored outside MEMORIA.
- `zero` and `menor` are ignored outside EXECUTA.
- Asserting `rst_n` low in any state, including mid-MEMORIA: strobes drop immediately (asynchronously) and `estado` returns to BUSCA. No partial write is re-issued.

## Structure
- `controle_pkg` holds the state encodings, opcode constants, funct3 branch codes and `aluop` codes.
- One combinational sub-module, `gerador_imediato`, takes IR and produces `imm_alu`, the branch magnitude, the sign and the overflow flag.
- The FSM, IR register and strobe decode stay in `unidade_controle`.

## Test plan
- Reset release, then `instrucao`=0x00208033 (add): `estado` sequence 0,1,2,4,8,0; `regwrite` high only in state 4; `pcsrc`=0.
- 0xFE208CE3 (beq x1,x2,−8) with `zero`=1: in state 8, `pcsrc`=1, `immediate`=8, `negativo`=1. Repeat with `zero`=0: `pcsrc`=0.
- Load 0x0000A103 with `mem_pronto` delayed 3 cycles: `memread` high for 4 cycles; `estado` 0,1,2,3,3,3,3,4,8.
- Opcode 1111111: `ilegal` pulses in DECODIFICA; next state 8 with `pcsrc`=0; then BUSCA.
- Branch with offset −4096 (0x80000063): `immediate`=0, `negativo`=1, `ilegal` pulse.
- Store with `rst_n` low during MEMORIA: `memwrite` drops asynchronously; after release `estado`=0 and all strobes are 0.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes,
// branch funct3 codes and ALU operation selectors.
package controle_pkg;

    typedef enum logic [3:0] {
        BUSCA       = 4'b0000,
        DECODIFICA  = 4'b0001,
        EXECUTA     = 4'b0010,
        MEMORIA     = 4'b0011,
        ESCRITA     = 4'b0100,
        ATUALIZA_PC = 4'b1000
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/unidade_controle_if.sv
// Signal bundle between the control unit (master) and the datapath /
// PC-update stage (slave).
interface unidade_controle_if;
    logic [31:0] instrucao;
    logic        zero;
    logic        menor;
    logic        mem_pronto;
    logic [3:0]  estado;
    logic        pcsrc;
    logic [11:0] immediate;
    logic        negativo;
    logic [31:0] imm_alu;
    logic        ir_write;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic [1:0]  aluop;
    logic        ilegal;

    modport master (
        input  instrucao, zero, menor, mem_pronto,
        output estado, pcsrc, immediate, negativo, imm_alu,
               ir_write, regwrite, memread, memwrite, alusrc, aluop, ilegal
    );

    modport slave (
        output instrucao, zero, menor, mem_pronto,
        input  estado, pcsrc, immediate, negativo, imm_alu,
               ir_write, regwrite, memread, memwrite, alusrc, aluop, ilegal
    );
endinterface

// File: rtl/unidade_controle_gerador.sv
// Combinational immediate generator: I/S immediates for the ALU and the
// branch offset split into magnitude and sign for the PC-update stage.
module gerador_imediato
    import controle_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm_alu,
    output logic [11:0] magnitude,
    output logic        negativo,
    output logic        estouro
);
    logic [12:0] off;
    logic [12:0] mag;
    logic        unused_bits;

    assign unused_bits = ^ir[19:12];

    always_comb begin
        imm_alu = 32'd0;
        case (ir[6:0])
            OP_I, OP_LOAD: imm_alu = {{20{ir[31]}}, ir[31:20]};
            OP_STORE:      imm_alu = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            default:       imm_alu = 32'd0;
        endcase
    end

    assign off      = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign negativo = off[12];
    assign mag      = off[12] ? (~off + 13'd1) : off;
    assign magnitude = mag[11:0];
    // -4096 has no 12-bit magnitude; it wraps to 0 and is flagged instead
    assign estouro  = off[12] & (off[11:0] == 12'd0);
endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/write-back/
// PC-update and drives the datapath strobes and PC-update stage inputs.
module unidade_controle
    import controle_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    unidade_controle_if.master bus
);
    estado_t     estado, proximo;
    logic [31:0] ir;
    logic [31:0] imm_alu_c, imm_alu_r;
    logic [11:0] mag, immediate_r;
    logic        neg, estouro, negativo_r, pcsrc_r;
    logic        is_r, is_i, is_load, is_store, is_branch, suportado;
    logic        branch_valido, tomado;

    gerador_imediato u_gerador (
        .ir        (ir),
        .imm_alu   (imm_alu_c),
        .magnitude (mag),
        .negativo  (neg),
        .estouro   (estouro)
    );

    assign is_r      = (ir[6:0] == OP_R);
    assign is_i      = (ir[6:0] == OP_I);
    assign is_load   = (ir[6:0] == OP_LOAD);
    assign is_store  = (ir[6:0] == OP_STORE);
    assign is_branch = (ir[6:0] == OP_BRANCH);
    assign suportado = is_r | is_i | is_load | is_store | is_branch;

    always_comb begin
        branch_valido = 1'b1;
        tomado        = 1'b0;
        case (ir[14:12])
            F3_BEQ:  tomado = bus.zero;
            F3_BNE:  tomado = ~bus.zero;
            F3_BLT:  tomado = bus.menor;
            F3_BGE:  tomado = ~bus.menor;
            default: branch_valido = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= BUSCA;
            ir          <= 32'd0;
            immediate_r <= 12'd0;
            negativo_r  <= 1'b0;
            imm_alu_r   <= 32'd0;
            pcsrc_r     <= 1'b0;
        end else begin
            estado <= proximo;
            if (estado == BUSCA)
                ir <= bus.instrucao;
            if (estado == DECODIFICA) begin
                immediate_r <= is_branch ? mag : 12'd0;
                negativo_r  <= is_branch & neg;
                imm_alu_r   <= imm_alu_c;
            end
            if (estado == EXECUTA && is_branch)
                pcsrc_r <= tomado & branch_valido;
            else if (estado == ATUALIZA_PC)
                pcsrc_r <= 1'b0;
        end
    end

    always_comb begin
        proximo      = estado;
        bus.ir_write = 1'b0;
        bus.regwrite = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.alusrc   = 1'b0;
        bus.aluop    = ALUOP_ADD;
        bus.ilegal   = 1'b0;
        case (estado)
            BUSCA: begin
                // gated so the strobe is already low while reset is held
                bus.ir_write = rst_n;
                proximo      = DECODIFICA;
            end
            DECODIFICA: begin
                bus.ilegal = ~suportado | (is_branch & estouro);
                proximo    = suportado ? EXECUTA : ATUALIZA_PC;
            end
            EXECUTA: begin
                bus.alusrc = is_i | is_load | is_store;
                if (is_branch)
                    bus.aluop = ALUOP_SUB;
                else if (is_r | is_i)
                    bus.aluop = ALUOP_FUNCT;
                bus.ilegal = is_branch & ~branch_valido;
                if (is_branch)
                    proximo = ATUALIZA_PC;
                else if (is_load | is_store)
                    proximo = MEMORIA;
                else
                    proximo = ESCRITA;
            end
            MEMORIA: begin
                bus.memread  = is_load;
                bus.memwrite = is_store;
                if (bus.mem_pronto)
                    proximo = is_load ? ESCRITA : ATUALIZA_PC;
            end
            ESCRITA: begin
                bus.regwrite = 1'b1;
                proximo      = ATUALIZA_PC;
            end
            ATUALIZA_PC: proximo = BUSCA;
            default:     proximo = BUSCA;
        endcase
    end

    assign bus.estado    = estado;
    assign bus.pcsrc     = pcsrc_r;
    assign bus.immediate = immediate_r;
    assign bus.negativo  = negativo_r;
    assign bus.imm_alu   = imm_alu_r;
endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks add, beq, load, illegal,
// -4096 branch and store-with-reset through the state sequence.
module tb_unidade_controle;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   nread;

    unidade_controle_if bus ();

    unidade_controle dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst_n          = 1'b0;
        bus.instrucao  = 32'h0020_8033;
        bus.zero       = 1'b0;
        bus.menor      = 1'b0;
        bus.mem_pronto = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_estado", bus.estado, 4'h0);
        chk("rst_ir_write", bus.ir_write, 1'b0);
        chk("rst_pcsrc", bus.pcsrc, 1'b0);
        chk("rst_immediate", bus.immediate, 12'd0);
        chk("rst_imm_alu", bus.imm_alu, 32'd0);
        chk("rst_ilegal", bus.ilegal, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // add x0,x1,x2
        chk("add_s0", bus.estado, 4'h0);
        chk("add_irw", bus.ir_write, 1'b1);
        tick(); chk("add_s1", bus.estado, 4'h1); chk("add_rw1", bus.regwrite, 1'b0);
        tick(); chk("add_s2", bus.estado, 4'h2); chk("add_aluop", bus.aluop, 2'b10);
        chk("add_alusrc", bus.alusrc, 1'b0);
        tick(); chk("add_s4", bus.estado, 4'h4); chk("add_rw4", bus.regwrite, 1'b1);
        tick(); chk("add_s8", bus.estado, 4'h8); chk("add_rw8", bus.regwrite, 1'b0);
        chk("add_pcsrc", bus.pcsrc, 1'b0);
        tick(); chk("add_s0b", bus.estado, 4'h0);

        // beq x1,x2,-8 taken
        bus.instrucao = 32'hFE20_8CE3;
        bus.zero      = 1'b1;
        tick(); chk("beq1_s1", bus.estado, 4'h1); chk("beq1_ilegal", bus.ilegal, 1'b0);
        tick(); chk("beq1_s2", bus.estado, 4'h2); chk("beq1_aluop", bus.aluop, 2'b01);
        tick(); chk("beq1_s8", bus.estado, 4'h8); chk("beq1_pcsrc", bus.pcsrc, 1'b1);
        chk("beq1_imm", bus.immediate, 12'd8); chk("beq1_neg", bus.negativo, 1'b1);
        tick(); chk("beq1_s0", bus.estado, 4'h0); chk("beq1_pcsrc_clr", bus.pcsrc, 1'b0);

        // beq not taken
        bus.zero = 1'b0;
        tick(); tick(); tick();
        chk("beq0_s8", bus.estado, 4'h8); chk("beq0_pcsrc", bus.pcsrc, 1'b0);
        chk("beq0_imm", bus.immediate, 12'd8);
        tick(); chk("beq0_s0", bus.estado, 4'h0);

        // lw x2,0(x1) with mem_pronto on the fourth MEMORIA cycle
        bus.instrucao = 32'h0000_A103;
        nread = 0;
        tick(); chk("lw_s1", bus.estado, 4'h1);
        tick(); chk("lw_s2", bus.estado, 4'h2); chk("lw_alusrc", bus.alusrc, 1'b1);
        chk("lw_aluop", bus.aluop, 2'b00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lw_s3", bus.estado, 4'h3);
            if (bus.memread === 1'b1) nread++;
            if (i == 3) bus.mem_pronto = 1'b1;
        end
        chk("lw_nread", nread, 4);
        tick(); chk("lw_s4", bus.estado, 4'h4); chk("lw_rw", bus.regwrite, 1'b1);
        chk("lw_mr_off", bus.memread, 1'b0);
        bus.mem_pronto = 1'b0;
        tick(); chk("lw_s8", bus.estado, 4'h8);
        tick(); chk("lw_s0", bus.estado, 4'h0);

        // unsupported opcode 1111111
        bus.instrucao = 32'h0000_007F;
        tick(); chk("ill_s1", bus.estado, 4'h1); chk("ill_pulse", bus.ilegal, 1'b1);
        tick(); chk("ill_s8", bus.estado, 4'h8); chk("ill_pcsrc", bus.pcsrc, 1'b0);
        chk("ill_drop", bus.ilegal, 1'b0); chk("ill_imm", bus.immediate, 12'd0);
        tick(); chk("ill_s0", bus.estado, 4'h0);

        // branch offset -4096
        bus.instrucao = 32'h8000_0063;
        bus.zero      = 1'b1;
        tick(); chk("ovf_s1", bus.estado, 4'h1); chk("ovf_pulse", bus.ilegal, 1'b1);
        tick(); chk("ovf_s2", bus.estado, 4'h2);
        tick(); chk("ovf_s8", bus.estado, 4'h8);
        chk("ovf_imm", bus.immediate, 12'd0); chk("ovf_neg", bus.negativo, 1'b1);
        tick(); chk("ovf_s0", bus.estado, 4'h0);
        bus.zero = 1'b0;

        // sw x2,0(x1), reset asserted mid-MEMORIA
        bus.instrucao = 32'h0020_A023;
        tick(); tick();
        chk("sw_imm_alu", bus.imm_alu, 32'd0);
        tick(); chk("sw_s3", bus.estado, 4'h3); chk("sw_mw", bus.memwrite, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("sw_mw_async", bus.memwrite, 1'b0);
        chk("sw_estado_async", bus.estado, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("sw_rel_s0", bus.estado, 4'h0);
        chk("sw_rel_mw", bus.memwrite, 1'b0);
        chk("sw_rel_mr", bus.memread, 1'b0);
        chk("sw_rel_rw", bus.regwrite, 1'b0);
        chk("sw_rel_imm", bus.immediate, 12'd0);
        tick(); chk("sw_rel_s1", bus.estado, 4'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
